serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor built around a single DIGIT-bit full-adder slice, with the carry kept in a register between cycles.
- Processes WIDTH-bit operands LSB-first, one DIGIT-bit slice per clock.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Serves as the area-minimal arithmetic unit next to the combinational ripple-carry adder in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DIGIT, 1, bits processed per clock. WIDTH % DIGIT != 0 is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- mode  in  1  0 = add, 1 = subtract; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- cin  in  1  add: carry-in; subtract: borrow-in. Captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- s  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB. In subtract mode, 1 = no borrow.
- ovf  out  1  signed overflow.

Behaviour:
- Reset:
  - busy=0, done=0, s=0, cout=0, ovf=0.
  - Internal carry, counter and shift registers cleared; FSM goes to IDLE.
  - rst has priority over every other input.
- FSM states: IDLE, RUN. N = WIDTH/DIGIT.
- IDLE:
  - start=1 at edge E captures a, mode, cin.
  - It also captures B' = mode ? ~b : b, and the carry register c = mode ? ~cin : cin.
  - So subtract computes a - b - cin = a + ~b + ~cin.
  - Counter is loaded with 0; busy=1 from edge E; FSM goes to RUN.
- RUN:
  - On each edge, the low DIGIT bits of the A/B' shift registers are added with c.
  - The sum slice shifts into the result register from the MSB side; c takes the slice carry; A/B' shift right by DIGIT.
  - The counter increments.
- Completion, at edge E+N:
  - s = assembled result; cout = final c.
  - ovf = carry into the MSB XOR carry out of the MSB, taken from the last slice.
  - busy=0, done=1, FSM returns to IDLE.
- done clears on the next edge unless a new operation completes there. It can never be high for two consecutive cycles when N ≥ 1.
- Latency: done is visible exactly N clock edges after the edge that accepted start. Throughput is one operation per N cycles.
- s, cout and ovf hold the previous result during RUN and update only at completion. They hold until the next completion or rst.
- start while busy=1 is ignored; captured operands are not disturbed.
- start in the cycle where done=1 (FSM in IDLE) is accepted, giving back-to-back operation; done falls on that edge and busy rises.
- a, b, mode and cin are don't-care except in the accepting cycle.
- rst during RUN aborts the operation: no done pulse, and outputs go to their reset values.
- DIGIT = WIDTH degenerates to N=1: single-cycle RUN, done one edge after accept.

Test Plan:
- WIDTH=8, DIGIT=1. rst for 2 cycles, then add a=100, b=27, cin=0 -> busy high for 8 cycles; done at accept+8; s=127, cout=0, ovf=0.
- Add a=100, b=28, cin=0 -> s=8'h80, cout=0, ovf=1. Then add a=8'hFF, b=8'h01, cin=1 -> s=8'h01, cout=1, ovf=0.
- Subtract a=5, b=7, cin=0 -> s=8'hFE, cout=0 (borrow), ovf=0. Then subtract a=8'h80, b=8'h01, cin=0 -> s=8'h7F, cout=1, ovf=1.
- Accept add 3+4. Pulse start with a=50, b=50 at RUN cycles 2 and 5 -> ignored; result s=7, single done. Next op: assert rst at RUN cycle 3 -> busy=0, s=0, no done. A following 1+1 -> s=2.
- WIDTH=16, DIGIT=4: add a=16'h1234, b=16'h0FFF, cin=0 -> done at accept+4; s=16'h2233, cout=0, ovf=0.
- Same config: raise start in the done cycle with a=16'hFFFF, b=16'h0001 -> accepted immediately; done 4 edges later; s=16'h0000, cout=1, ovf=0. Prior result is held during RUN.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor built around one DIGIT-bit
// adder slice. Operands are consumed LSB-first, one slice per clock, with the
// inter-slice carry held in a register. Subtraction is a + ~b + ~cin.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst    synchronous active-high reset, overrides everything
//   start  request, only looked at while idle
//   mode   0 = add, 1 = subtract (captured with start)
//   a, b   WIDTH-bit operands (captured with start)
//   cin    carry-in (add) / borrow-in (subtract), captured with start
//   busy   high while an operation is in flight
//   done   one-cycle pulse when s/cout/ovf carry a fresh result
//   s      result, held between completions
//   cout   raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf    signed overflow
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtract
  logic             c_q;      // carry between slices
  logic [WIDTH-1:0] r_q;      // result being assembled, filled from the MSB side
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT:0]   slice_sum;
  logic             c_d;
  logic             msb_cin;
  logic [WIDTH-1:0] r_d;

  // The single DIGIT-bit adder slice.
  always_comb begin
    slice_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    c_d       = slice_sum[DIGIT];
    // Carry into the slice's top bit recovered from its sum bit; on the last
    // slice this is the carry into the operand MSB.
    msb_cin   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1];
    r_d       = (r_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= mode ? ~b : b;
            c_q     <= mode ? ~cin : cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          c_q   <= c_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            s_q     <= r_d;
            cout_q  <= c_d;
            ovf_q   <= msb_cin ^ c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: two instances (8-bit/1-bit slices and
// 16-bit/4-bit slices) checked every cycle against an arithmetic model,
// plus directed operations with literal expected results.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, mode8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, s8;
  logic        rst16, start16, mode16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, s16;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst16), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .cin(cin16), .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } res_t;

  function automatic int wid(int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic int nsl(int k);
    return (k == 0) ? 8 : 4;
  endfunction

  // Plain arithmetic reference: a + b' + c' evaluated in a wide integer.
  function automatic res_t arith(int w, logic m, logic [15:0] a, logic [15:0] b, logic ci);
    logic [31:0] mask, bb, full;
    res_t r;
    mask = (32'd1 << w) - 32'd1;
    bb   = m ? (~{16'h0, b} & mask) : ({16'h0, b} & mask);
    full = ({16'h0, a} & mask) + bb + {31'h0, (m ? ~ci : ci)};
    r.s  = full[15:0] & mask[15:0];
    r.co = full[w];
    r.ov = (a[w-1] == bb[w-1]) && (r.s[w-1] != a[w-1]);
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(int k, logic st, logic m, logic [15:0] a, logic [15:0] b, logic ci);
    if (k == 0) begin
      start8 = st; mode8 = m; a8 = a[7:0]; b8 = b[7:0]; cin8 = ci;
    end else begin
      start16 = st; mode16 = m; a16 = a; b16 = b; cin16 = ci;
    end
  endtask

  task automatic set_rst(int k, logic v);
    if (k == 0) rst8 = v; else rst16 = v;
  endtask

  function automatic logic g_busy(int k); return (k == 0) ? busy8 : busy16; endfunction
  function automatic logic g_done(int k); return (k == 0) ? done8 : done16; endfunction
  function automatic logic g_cout(int k); return (k == 0) ? cout8 : cout16; endfunction
  function automatic logic g_ovf(int k);  return (k == 0) ? ovf8  : ovf16;  endfunction
  function automatic logic [15:0] g_s(int k); return (k == 0) ? {8'h0, s8} : s16; endfunction

  function automatic logic in_rst(int k);   return (k == 0) ? rst8   : rst16;   endfunction
  function automatic logic in_start(int k); return (k == 0) ? start8 : start16; endfunction
  function automatic logic in_mode(int k);  return (k == 0) ? mode8  : mode16;  endfunction
  function automatic logic in_cin(int k);   return (k == 0) ? cin8   : cin16;   endfunction
  function automatic logic [15:0] in_a(int k); return (k == 0) ? {8'h0, a8} : a16; endfunction
  function automatic logic [15:0] in_b(int k); return (k == 0) ? {8'h0, b8} : b16; endfunction

  // Behavioural model: an accepted operation finishes exactly nsl(k) edges later.
  res_t m_out[2];
  res_t m_pend[2];
  logic m_busy[2];
  logic m_done[2];
  int   m_rem[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (in_rst(k)) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_out[k]  <= '0;
        m_rem[k]  <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_busy[k]) begin
          m_rem[k] <= m_rem[k] - 1;
          if (m_rem[k] == 1) begin
            m_busy[k] <= 1'b0;
            m_done[k] <= 1'b1;
            m_out[k]  <= m_pend[k];
          end
        end else if (in_start(k)) begin
          m_busy[k] <= 1'b1;
          m_rem[k]  <= nsl(k);
          m_pend[k] <= arith(wid(k), in_mode(k), in_a(k), in_b(k), in_cin(k));
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("w%0d_busy", wid(k)), 32'(g_busy(k)), 32'(m_busy[k]));
        check($sformatf("w%0d_done", wid(k)), 32'(g_done(k)), 32'(m_done[k]));
        check($sformatf("w%0d_s", wid(k)),    32'(g_s(k)),    32'(m_out[k].s));
        check($sformatf("w%0d_cout", wid(k)), 32'(g_cout(k)), 32'(m_out[k].co));
        check($sformatf("w%0d_ovf", wid(k)),  32'(g_ovf(k)),  32'(m_out[k].ov));
      end
    end
  end

  // Caller sits at a falling edge; start is taken on the next rising edge.
  task automatic issue(int k, logic m, logic [15:0] a, logic [15:0] b, logic ci);
    drive(k, 1'b1, m, a, b, ci);
  endtask

  task automatic wait_done(int k, string nm, logic [15:0] es, logic eco, logic eov,
                           bit chk_hold, logic [15:0] hold_v);
    int lat;
    @(negedge clk);
    drive(k, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    check({nm, "_busy0"}, 32'(g_busy(k)), 32'd1);
    if (chk_hold) check({nm, "_hold"}, 32'(g_s(k)), 32'(hold_v));
    lat = 0;
    while (!g_done(k) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"},  32'(lat),       32'(nsl(k)));
    check({nm, "_s"},    32'(g_s(k)),    32'(es));
    check({nm, "_cout"}, 32'(g_cout(k)), 32'(eco));
    check({nm, "_ovf"},  32'(g_ovf(k)),  32'(eov));
  endtask

  initial begin
    int   lat;
    int   dones;
    res_t r;

    rst8 = 1'b1; rst16 = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst16 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", 32'(g_busy(k)), 32'd0);
      check("rst_done", 32'(g_done(k)), 32'd0);
      check("rst_s",    32'(g_s(k)),    32'd0);
      check("rst_cout", 32'(g_cout(k)), 32'd0);
      check("rst_ovf",  32'(g_ovf(k)),  32'd0);
    end
    chk_en = 1'b1;

    // Pin the reference arithmetic with hand-worked values.
    r = arith(8, 1'b0, 16'd100, 16'd28, 1'b0);
    check("pin_add_ovf", 32'(r), 32'({16'h0080, 1'b0, 1'b1}));
    r = arith(8, 1'b1, 16'd5, 16'd7, 1'b0);
    check("pin_sub_borrow", 32'(r), 32'({16'h00FE, 1'b0, 1'b0}));
    r = arith(16, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    check("pin_add16_wrap", 32'(r), 32'({16'h0000, 1'b1, 1'b0}));

    // 8-bit, one bit per clock
    @(negedge clk); issue(0, 1'b0, 16'd100, 16'd27, 1'b0);
    wait_done(0, "add127", 16'd127, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); issue(0, 1'b0, 16'd100, 16'd28, 1'b0);
    wait_done(0, "add128", 16'h80, 1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk); issue(0, 1'b0, 16'hFF, 16'h01, 1'b1);
    wait_done(0, "addff", 16'h01, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge clk); issue(0, 1'b1, 16'd5, 16'd7, 1'b0);
    wait_done(0, "sub5m7", 16'hFE, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); issue(0, 1'b1, 16'h80, 16'h01, 1'b0);
    wait_done(0, "sub80m1", 16'h7F, 1'b1, 1'b1, 1'b0, 16'h0);

    // start pulses while busy must be ignored
    @(negedge clk); issue(0, 1'b0, 16'd3, 16'd4, 1'b0);
    lat = 0; dones = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      lat = i - 1;
      drive(0, (i == 3 || i == 6), 1'b0, 16'd50, 16'd50, 1'b0);
      if (done8) break;
    end
    check("ign_lat", 32'(lat), 32'd8);
    check("ign_s",   32'(s8),  32'd7);
    @(negedge clk);
    check("ign_single_done", 32'(done8), 32'd0);

    // reset in the middle of a run aborts it
    issue(0, 1'b0, 16'd9, 16'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      rst8 = (i == 2);
    end
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_s",    32'(s8),    32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    issue(0, 1'b0, 16'd1, 16'd1, 1'b0);
    wait_done(0, "add1p1", 16'd2, 1'b0, 1'b0, 1'b0, 16'h0);

    // 16-bit, four bits per clock, then back-to-back from the done cycle
    @(negedge clk); issue(1, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
    wait_done(1, "add16", 16'h2233, 1'b0, 1'b0, 1'b0, 16'h0);
    issue(1, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait_done(1, "b2b16", 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2233);

    // randomized traffic on both instances, including odd resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        drive(k, ($urandom_range(0, 2) == 0), 1'($urandom), 16'($urandom),
              16'($urandom), 1'($urandom));
        set_rst(k, ($urandom_range(0, 149) == 0));
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      set_rst(k, 1'b0);
    end
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
